// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 800x600@60 timing constants and count type
// Purpose: default raster timing for the 40 MHz pixel clock, shared with draw stages.
// Ports: none (package).
`timescale 1ns/1ps
package vga_pkg;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] count_t;

  localparam int H_VISIBLE = 800;
  localparam int H_FPORCH  = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BPORCH  = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;

  localparam int V_VISIBLE = 600;
  localparam int V_FPORCH  = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BPORCH  = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

  localparam int MAX_TOTAL = 1 << CNT_W;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA stream bus between timing source and draw stages
// Purpose: bundles the raster counts, sync/blank flags, colour and frame tick.
// Ports: master drives everything (timing generator / draw stage output),
//        slave observes everything (next draw stage / screen multiplexer).
`timescale 1ns/1ps
interface vga_timing_gen_if;
  import vga_pkg::*;

  count_t      hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  count_t      vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        frame_tick;

  modport master (
    output hcount_out, hsync_out, hblnk_out,
    output vcount_out, vsync_out, vblnk_out,
    output rgb_out, frame_tick
  );

  modport slave (
    input hcount_out, hsync_out, hblnk_out,
    input vcount_out, vsync_out, vblnk_out,
    input rgb_out, frame_tick
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one raster axis: wrapping counter with blank/sync decode
// Purpose: counts 0..TOTAL-1, stepping when en && inc; blank and sync flags are
//          decoded from the next count and registered with it, so they always
//          describe the count presented on cnt.
// Ports: clk, rst_n (async, active-low), en (global enable), inc (step request),
//        cnt (registered count), blnk, sync (registered flags),
//        wrap (combinational: the coming edge takes cnt from TOTAL-1 to 0).
`timescale 1ns/1ps
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int VISIBLE    = H_VISIBLE,
  parameter int SYNC_START = H_VISIBLE + H_FPORCH,
  parameter int SYNC_LEN   = H_SYNC,
  parameter bit POL        = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   inc,
  output count_t cnt,
  output logic   blnk,
  output logic   sync,
  output logic   wrap
);

  // Comparisons use one extra bit so a sync window ending exactly at 4096 still decodes.
  typedef logic [CNT_W:0] ext_t;
  localparam ext_t LAST     = ext_t'(TOTAL - 1);
  localparam ext_t VIS      = ext_t'(VISIBLE);
  localparam ext_t SYNC_BEG = ext_t'(SYNC_START);
  localparam ext_t SYNC_END = ext_t'(SYNC_START + SYNC_LEN);

  if (TOTAL > MAX_TOTAL) begin : g_total_chk
    $error("vga_axis_cnt: TOTAL exceeds 12-bit count range");
  end

  count_t cnt_q, cnt_d;
  logic   blnk_q, blnk_d;
  logic   sync_q, sync_d;
  logic   step;
  logic   at_last;
  logic   in_sync;

  assign step    = en & inc;
  assign at_last = ({1'b0, cnt_q} == LAST);
  assign wrap    = step & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
    // When nothing steps cnt_d == cnt_q, so the decode reproduces the held flags.
    blnk_d  = ({1'b0, cnt_d} >= VIS);
    in_sync = ({1'b0, cnt_d} >= SYNC_BEG) && ({1'b0, cnt_d} < SYNC_END);
    sync_d  = POL ? in_sync : ~in_sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign blnk = blnk_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing source (default 800x600@60, 40 MHz)
// Purpose: drives the VGA stream bus with aligned counts, sync/blank flags,
//          black rgb and a one-cycle frame-start tick.
// Ports: pclk (pixel clock), rst_n (async, active-low), en (0 freezes all outputs),
//        vga (master side of the VGA stream bus).
`timescale 1ns/1ps
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FPORCH  = vga_pkg::H_FPORCH,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BPORCH  = vga_pkg::H_BPORCH,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FPORCH  = vga_pkg::V_FPORCH,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BPORCH  = vga_pkg::V_BPORCH,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              en,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOT = H_VISIBLE + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOT = V_VISIBLE + V_FPORCH + V_SYNC + V_BPORCH;

  if (H_TOT > MAX_TOTAL) begin : g_h_chk
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOT > MAX_TOTAL) begin : g_v_chk
    $error("vga_timing_gen: V_TOTAL exceeds 4096");
  end

  count_t h_cnt, v_cnt;
  logic   h_blnk, h_sync, h_wrap;
  logic   v_blnk, v_sync, v_wrap;
  logic   tick_q, tick_d;

  vga_axis_cnt #(
    .TOTAL      (H_TOT),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FPORCH),
    .SYNC_LEN   (H_SYNC),
    .POL        (SYNC_POL)
  ) u_h_cnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (en),
    .cnt   (h_cnt),
    .blnk  (h_blnk),
    .sync  (h_sync),
    .wrap  (h_wrap)
  );

  vga_axis_cnt #(
    .TOTAL      (V_TOT),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FPORCH),
    .SYNC_LEN   (V_SYNC),
    .POL        (SYNC_POL)
  ) u_v_cnt (
    .clk   (pclk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (h_wrap),
    .cnt   (v_cnt),
    .blnk  (v_blnk),
    .sync  (v_sync),
    .wrap  (v_wrap)
  );

  // Next counts are (0,0) exactly when the vertical axis wraps (which already
  // implies the horizontal wrap); with en low the tick holds like every other output.
  always_comb begin
    tick_d = tick_q;
    if (en) begin
      tick_d = v_wrap;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign vga.hcount_out = h_cnt;
  assign vga.hsync_out  = h_sync;
  assign vga.hblnk_out  = h_blnk;
  assign vga.vcount_out = v_cnt;
  assign vga.vsync_out  = v_sync;
  assign vga.vblnk_out  = v_blnk;
  assign vga.rgb_out    = 12'h000;
  assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst_a = 1'b0, en_a = 1'b1;
  logic rst_b = 1'b0, en_b = 1'b1;

  int nvec = 0;
  int nerr = 0;

  // Model state: expected counts for each instance.
  int ah = 0, av = 0;
  int bh = 0, bv = 0;

  always #12.5 pclk = ~pclk;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  // Full-size 800x600 instance, active-high sync.
  vga_timing_gen dut_a (
    .pclk  (pclk),
    .rst_n (rst_a),
    .en    (en_a),
    .vga   (vga_a)
  );

  // Reduced 25x16 raster, active-low sync, so whole frames fit the cycle budget.
  vga_timing_gen #(
    .H_VISIBLE (16), .H_FPORCH (2), .H_SYNC (4), .H_BPORCH (3),
    .V_VISIBLE (10), .V_FPORCH (1), .V_SYNC (2), .V_BPORCH (3),
    .SYNC_POL  (1'b0)
  ) dut_b (
    .pclk  (pclk),
    .rst_n (rst_b),
    .en    (en_b),
    .vga   (vga_b)
  );

  task automatic vchk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // 800x600: hblnk >= 800, hsync 840..967 high, vblnk >= 600, vsync 601..604 high.
  task automatic chk_a(input string tag, input int eh, input int ev, input bit etick);
    vchk({tag, "_h"},     32'(vga_a.hcount_out), 32'(eh));
    vchk({tag, "_v"},     32'(vga_a.vcount_out), 32'(ev));
    vchk({tag, "_hblnk"}, 32'(vga_a.hblnk_out),  32'(eh >= 800));
    vchk({tag, "_hsync"}, 32'(vga_a.hsync_out),  32'(eh >= 840 && eh <= 967));
    vchk({tag, "_vblnk"}, 32'(vga_a.vblnk_out),  32'(ev >= 600));
    vchk({tag, "_vsync"}, 32'(vga_a.vsync_out),  32'(ev >= 601 && ev <= 604));
    vchk({tag, "_tick"},  32'(vga_a.frame_tick), 32'(etick));
    vchk({tag, "_rgb"},   32'(vga_a.rgb_out),    32'h0);
  endtask

  // 25x16 active-low: hblnk >= 16, hsync low 18..21, vblnk >= 10, vsync low 11..12.
  task automatic chk_b(input string tag, input int eh, input int ev, input bit etick);
    vchk({tag, "_h"},     32'(vga_b.hcount_out), 32'(eh));
    vchk({tag, "_v"},     32'(vga_b.vcount_out), 32'(ev));
    vchk({tag, "_hblnk"}, 32'(vga_b.hblnk_out),  32'(eh >= 16));
    vchk({tag, "_hsync"}, 32'(vga_b.hsync_out),  32'(!(eh >= 18 && eh <= 21)));
    vchk({tag, "_vblnk"}, 32'(vga_b.vblnk_out),  32'(ev >= 10));
    vchk({tag, "_vsync"}, 32'(vga_b.vsync_out),  32'(!(ev >= 11 && ev <= 12)));
    vchk({tag, "_tick"},  32'(vga_b.frame_tick), 32'(etick));
    vchk({tag, "_rgb"},   32'(vga_b.rgb_out),    32'h0);
  endtask

  task automatic step_a();
    @(posedge pclk);
    @(negedge pclk);
    if (rst_a && en_a) begin
      ah++;
      if (ah == 1056) begin
        ah = 0;
        av++;
        if (av == 628) av = 0;
      end
    end
  endtask

  task automatic step_b();
    @(posedge pclk);
    @(negedge pclk);
    if (rst_b && en_b) begin
      bh++;
      if (bh == 25) begin
        bh = 0;
        bv++;
        if (bv == 16) bv = 0;
      end
    end
  endtask

  initial begin
    int last_tick;
    int cyc;

    // Test 1: reset held 5 cycles with en=1.
    @(negedge pclk);
    for (int i = 0; i < 5; i++) begin
      chk_a("a_rst", 0, 0, 1'b1);
      step_a();
    end
    rst_a = 1'b1;
    chk_a("a_rel", 0, 0, 1'b1);
    step_a();
    chk_a("a_first", 1, 0, 1'b0);

    // Test 2: two full lines plus part of a third; covers hblnk/hsync edges and line wrap.
    while (!(av == 2 && ah == 500)) begin
      step_a();
      chk_a("a_run", ah, av, (ah == 0 && av == 0));
    end
    vchk("a_at500_h", 32'(vga_a.hcount_out), 32'd500);
    vchk("a_at500_v", 32'(vga_a.vcount_out), 32'd2);

    // Test 4: freeze for 10 cycles mid-line, then resume at 501.
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_a();
      chk_a("a_frz", 500, 2, 1'b0);
    end
    en_a = 1'b1;
    step_a();
    vchk("a_resume_h", 32'(vga_a.hcount_out), 32'd501);
    chk_a("a_resume", 501, 2, 1'b0);

    // Run into the hsync window so the async reset visibly clears an active sync.
    while (ah != 900) begin
      step_a();
      chk_a("a_run2", ah, av, 1'b0);
    end
    vchk("a_pre_rst_hsync", 32'(vga_a.hsync_out), 32'd1);

    // Test 5: async reset between edges, observed before the next pclk rise.
    #3;
    rst_a = 1'b0;
    #1;
    ah = 0;
    av = 0;
    chk_a("a_async", 0, 0, 1'b1);
    @(negedge pclk);
    chk_a("a_async_hold", 0, 0, 1'b1);
    rst_a = 1'b1;
    chk_a("a_rel2", 0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step_a();
      chk_a("a_restart", i, 0, 1'b0);
    end

    // Test 3/6 on the reduced active-low instance: reset idle levels, two frames, tick period.
    chk_b("b_rst", 0, 0, 1'b1);
    @(negedge pclk);
    rst_b = 1'b1;
    chk_b("b_rel", 0, 0, 1'b1);
    last_tick = 0;
    cyc = 0;
    for (int i = 0; i < 800; i++) begin
      step_b();
      cyc++;
      chk_b("b_run", bh, bv, (bh == 0 && bv == 0));
      if (vga_b.frame_tick === 1'b1) begin
        vchk("b_tick_period", 32'(cyc - last_tick), 32'd400);
        last_tick = cyc;
      end
    end
    vchk("b_frames_end_h", 32'(vga_b.hcount_out), 32'd0);

    // Freeze at (0,0): frame_tick must stay high with the held outputs.
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_b();
      chk_b("b_frz00", 0, 0, 1'b1);
    end
    en_b = 1'b1;
    step_b();
    chk_b("b_resume", 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
